bit_serializer: RTL and testbench

//   Parallel-to-serial front end for the sequence-detector FSMs. Accepts WIDTH-bit words over a

---
 rtl/ser_pkg.sv | 22 ++
 rtl/bit_tick_gen.sv | 43 ++++
 rtl/bit_serializer.sv | 150 +++++++++++++++
 tb/tb_bit_serializer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// Shared types and width helpers for the bit serializer.
// Latency: n/a (package).
// Backpressure: n/a (package).
`timescale 1ns/1ps
package ser_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2
    } ser_state_t;

    // Must hold the values 0..width.
    function automatic int bit_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic int div_cnt_w(input int clk_div);
        return (clk_div <= 2) ? 1 : $clog2(clk_div);
    endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period timer: bit_stb on the first clk of a period, period_end on the last.
// Latency: strobes are combinational from the counter; the counter restarts the clk after clr.
// Backpressure: none; it only counts while en is high.
`timescale 1ns/1ps
module bit_tick_gen
    import ser_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic bit_stb,
    output logic period_end
);

    localparam int DW = div_cnt_w(CLK_DIV);

    logic [DW-1:0] div_cnt_q;
    logic [DW-1:0] div_cnt_d;

    assign bit_stb    = en && (div_cnt_q == '0);
    assign period_end = en && (div_cnt_q == DW'(CLK_DIV - 1));

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (clr || period_end || !en) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/bit_serializer.sv
// Word-to-serial shifter (MSB first) with a one-word holding buffer; SER_PARITY_EN adds an even-parity bit.
// Latency: first bit on ser_out 1 clk after the transfer; buffered words follow with zero gap.
// Backpressure: in_ready drops while the holding buffer is full.
`timescale 1ns/1ps
module bit_serializer
    import ser_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             bit_stb,
    output logic             word_done,
    output logic             busy
);

    localparam int BCW = bit_cnt_w(WIDTH);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

    ser_state_t       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic             par_q, par_d;

    logic xfer, load, tick_stb, period_end, last_data, frame_end, active;

    assign active    = (state_q != S_IDLE);
    assign in_ready  = !hold_full_q && !rst;
    assign xfer      = in_valid && in_ready;
    assign last_data = (state_q == S_SHIFT) && period_end && (bit_cnt_q == LAST_BIT);
`ifdef SER_PARITY_EN
    assign frame_end = (state_q == S_PARITY) && period_end;
`else
    assign frame_end = last_data;
`endif

    bit_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk        (clk),
        .rst        (rst),
        .en         (active),
        .clr        (load),
        .bit_stb    (tick_stb),
        .period_end (period_end)
    );

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        bit_cnt_d   = bit_cnt_q;
        par_d       = par_q;
        load        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    state_d   = S_SHIFT;
                    shift_d   = in_data;
                    par_d     = ^in_data;
                    bit_cnt_d = '0;
                    load      = 1'b1;
                end
            end
            S_SHIFT: begin
                if (period_end && !last_data) begin
                    shift_d   = {shift_q[WIDTH-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                end
`ifdef SER_PARITY_EN
                if (last_data) begin
                    state_d   = S_PARITY;
                    bit_cnt_d = '0;
                end
`endif
            end
            S_PARITY: begin
            end
            default: state_d = S_IDLE;
        endcase

        // Frame end: buffered word first, else a word arriving this very cycle, else idle.
        if (frame_end) begin
            bit_cnt_d = '0;
            if (hold_full_q) begin
                state_d     = S_SHIFT;
                shift_d     = hold_q;
                par_d       = ^hold_q;
                hold_full_d = 1'b0;
                load        = 1'b1;
            end else if (xfer) begin
                state_d = S_SHIFT;
                shift_d = in_data;
                par_d   = ^in_data;
                load    = 1'b1;
            end else begin
                state_d = S_IDLE;
            end
        end

        if (xfer && active && !frame_end) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            bit_cnt_q   <= '0;
            par_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            bit_cnt_q   <= bit_cnt_d;
            par_q       <= par_d;
        end
    end

    always_comb begin
        ser_out = 1'b0;
        case (state_q)
            S_SHIFT:  ser_out = shift_q[WIDTH-1];
            S_PARITY: ser_out = par_q;
            default:  ser_out = 1'b0;
        endcase
        if (rst) begin
            ser_out = 1'b0;
        end
    end

    assign ser_valid = active && !rst;
    assign bit_stb   = tick_stb && !rst;
    assign word_done = frame_end && !rst;
    assign busy      = (active || hold_full_q) && !rst;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: two instances (CLK_DIV=1 and 3) checked cycle by cycle
// against a queue of expected per-clk output samples built from the sent words.
`timescale 1ns/1ps
module tb_bit_serializer;

    localparam int W = 8;

    typedef struct packed {
        logic b;
        logic stb;
        logic done;
    } ent_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         sel = 1'b0;

    logic r0, s0, v0, t0, d0, b0;
    logic r1, s1, v1, t1, d1, b1;

    int total = 0;
    int bad   = 0;
    ent_t q[$];

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(W), .CLK_DIV(1)) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid && !sel),
        .in_ready  (r0),
        .ser_out   (s0),
        .ser_valid (v0),
        .bit_stb   (t0),
        .word_done (d0),
        .busy      (b0)
    );

    bit_serializer #(.WIDTH(W), .CLK_DIV(3)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid && sel),
        .in_ready  (r1),
        .ser_out   (s1),
        .ser_valid (v1),
        .bit_stb   (t1),
        .word_done (d1),
        .busy      (b1)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s dut%0d t=%0t observed=%b expected=%b", tag, sel, $time, obs, exp);
        end
    endtask

    // A frame is WIDTH data bits MSB first (plus even parity when enabled), each held cdiv clks.
    task automatic push_frame(input logic [W-1:0] word, input int cdiv);
        int   ones;
        int   nbits;
        logic bits[$];
        ent_t e;
        ones = 0;
        for (int i = W - 1; i >= 0; i--) begin
            bits.push_back(word[i]);
            if (word[i]) ones++;
        end
`ifdef SER_PARITY_EN
        bits.push_back(logic'(ones % 2));
`endif
        nbits = bits.size();
        for (int i = 0; i < nbits; i++) begin
            for (int c = 0; c < cdiv; c++) begin
                e.b    = bits[i];
                e.stb  = (c == 0);
                e.done = (i == nbits - 1) && (c == cdiv - 1);
                q.push_back(e);
            end
        end
    endtask

    task automatic step();
        logic e_rdy, e_out, e_vld, e_stb, e_done, e_busy, xfer;
        int   frames;
        @(negedge clk);
        frames = 0;
        foreach (q[i]) if (q[i].done) frames++;
        e_rdy = !rst && (frames < 2);
        e_vld = !rst && (q.size() > 0);
        e_busy = e_vld;
        e_out = e_vld ? q[0].b : 1'b0;
        e_stb = e_vld ? q[0].stb : 1'b0;
        e_done = e_vld ? q[0].done : 1'b0;
        chk("in_ready",  sel ? r1 : r0, e_rdy);
        chk("ser_valid", sel ? v1 : v0, e_vld);
        chk("ser_out",   sel ? s1 : s0, e_out);
        chk("bit_stb",   sel ? t1 : t0, e_stb);
        chk("word_done", sel ? d1 : d0, e_done);
        chk("busy",      sel ? b1 : b0, e_busy);
        xfer = in_valid && e_rdy;
        @(posedge clk);
        if (rst) begin
            q.delete();
        end else begin
            if (q.size() > 0) void'(q.pop_front());
            if (xfer) push_frame(in_data, sel ? 3 : 1);
        end
        #1;
    endtask

    task automatic send(input logic [W-1:0] word);
        in_valid = 1'b1;
        in_data  = word;
        step();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic random_run(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = W'($urandom);
            step();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Single word, CLK_DIV=1
        sel = 1'b0;
        idle(1);
        send(8'hB0);
        idle(10);

        // Back-to-back words with in_valid held, then a pulse while the buffer is full
        in_valid = 1'b1;
        in_data  = 8'hB0;
        step();
        in_data  = 8'h0B;
        step();
        in_data  = 8'hEE;
        step();
        in_valid = 1'b0;
        idle(20);

        random_run(80);
        idle(25);

        // Reset mid-word with a word buffered
        send(8'hFF);
        send(8'h3C);
        idle(2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle(12);

        // CLK_DIV=3 instance
        sel = 1'b1;
        idle(2);
        send(8'hA5);
        idle(30);
        send(8'h07);
        idle(35);
        random_run(150);
        idle(70);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
